// File: rtl/countdown_timer_core_if.sv
// Control inputs and count/status outputs of the countdown timer core.
// Latency: none (wiring only). Backpressure: none; all signals are levels or single-cycle pulses.
// The master drives controls and observes status; the slave is the timer core.
interface countdown_timer_core_if #(
    parameter int MIN_W = 7
);
    logic             tick;
    logic             load;
    logic [MIN_W-1:0] load_min;
    logic [5:0]       load_sec;
    logic             start;
    logic             stop;
    logic             hold;
    logic             auto_reload;
    logic [MIN_W-1:0] Qm;
    logic [5:0]       Qs;
    logic             running;
    logic             paused;
    logic             done;
    logic             expired;
    logic             warn;

    modport master (
        output tick, load, load_min, load_sec, start, stop, hold, auto_reload,
        input  Qm, Qs, running, paused, done, expired, warn
    );

    modport slave (
        input  tick, load, load_min, load_sec, start, stop, hold, auto_reload,
        output Qm, Qs, running, paused, done, expired, warn
    );
endinterface

// File: rtl/countdown_timer_core.sv
// Minutes/seconds countdown timer with load, start/stop, hold freeze, auto-reload and low-time warning.
// Latency: count, load and control take effect one CLK after the qualifying input; expired is registered.
// Backpressure: none; tick is a one-cycle enable and ticks arriving with load or stop are dropped.
module countdown_timer_core #(
    parameter int MIN_W    = 7,
    parameter int MAX_MIN  = 99,
    parameter int WARN_SEC = 10
) (
    input  logic CLK,
    input  logic RST,
    countdown_timer_core_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);
    localparam logic [5:0]       WARN_V    = 6'(WARN_SEC);

    state_t           state, state_n;
    logic [MIN_W-1:0] qm, qm_n, rl_m, rl_m_n;
    logic [5:0]       qs, qs_n, rl_s, rl_s_n;
    logic             expired_q, expired_n;

    logic [MIN_W-1:0] sat_min;
    logic [5:0]       sat_sec;
    logic             count_zero;
    logic             reload_zero;

    assign sat_min     = (bus.load_min > MAX_MIN_V) ? MAX_MIN_V : bus.load_min;
    assign sat_sec     = (bus.load_sec > 6'd59) ? 6'd59 : bus.load_sec;
    assign count_zero  = (qm == '0) && (qs == 6'd0);
    assign reload_zero = (rl_m == '0) && (rl_s == 6'd0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            qm        <= '0;
            qs        <= 6'd0;
            rl_m      <= '0;
            rl_s      <= 6'd0;
            expired_q <= 1'b0;
        end else begin
            state     <= state_n;
            qm        <= qm_n;
            qs        <= qs_n;
            rl_m      <= rl_m_n;
            rl_s      <= rl_s_n;
            expired_q <= expired_n;
        end
    end

    always_comb begin
        state_n   = state;
        qm_n      = qm;
        qs_n      = qs;
        rl_m_n    = rl_m;
        rl_s_n    = rl_s;
        expired_n = 1'b0;

        if (bus.load) begin
            qm_n    = sat_min;
            qs_n    = sat_sec;
            rl_m_n  = sat_min;
            rl_s_n  = sat_sec;
            state_n = IDLE;
        end else if (bus.start && (state != RUN)) begin
            // start in RUN is a no-op, so stop/decrement below still get their turn
            if (state == DONE) begin
                qm_n    = rl_m;
                qs_n    = rl_s;
                state_n = reload_zero ? DONE : RUN;
            end else if (!count_zero) begin
                state_n = RUN;
            end
        end else if (bus.stop) begin
            if (state == RUN)
                state_n = PAUSE;
        end else if ((state == RUN) && bus.tick && !bus.hold) begin
            if ((qm == '0) && (qs == 6'd1)) begin
                expired_n = 1'b1;
                if (bus.auto_reload) begin
                    qm_n = rl_m;
                    qs_n = rl_s;
                end else begin
                    qm_n    = '0;
                    qs_n    = 6'd0;
                    state_n = DONE;
                end
            end else if (qs != 6'd0) begin
                qs_n = qs - 6'd1;
            end else if (qm != '0) begin
                qs_n = 6'd59;
                qm_n = qm - MIN_W'(1);
            end
        end
    end

    assign bus.Qm      = qm;
    assign bus.Qs      = qs;
    assign bus.running = (state == RUN);
    assign bus.paused  = (state == PAUSE);
    assign bus.done    = (state == DONE);
    assign bus.expired = expired_q;
    assign bus.warn    = (state == RUN) && (qm == '0) && (qs <= WARN_V) && (qs != 6'd0);
endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed self-checking bench for countdown_timer_core: load, count, expiry, auto-reload,
// saturation, hold, stop/start, warning and asynchronous reset.
module tb_countdown_timer_core;
    localparam int MIN_W = 7;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    countdown_timer_core_if #(.MIN_W(MIN_W)) bus ();

    countdown_timer_core #(
        .MIN_W   (MIN_W),
        .MAX_MIN (99),
        .WARN_SEC(10)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // minutes*100+seconds, so 1:02 reads as 102
    function automatic logic [31:0] mmss();
        return 32'(bus.Qm) * 100 + 32'(bus.Qs);
    endfunction

    task automatic do_load(input int m, input int s);
        bus.load     = 1'b1;
        bus.load_min = MIN_W'(m);
        bus.load_sec = 6'(s);
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
    endtask

    initial begin
        bus.tick = 0; bus.load = 0; bus.load_min = '0; bus.load_sec = '0;
        bus.start = 0; bus.stop = 0; bus.hold = 0; bus.auto_reload = 0;

        // reset state
        cyc(); cyc();
        RST = 1'b0;
        cyc();
        chk("rst_count", mmss(), 0);
        chk("rst_flags", {bus.running, bus.paused, bus.done, bus.expired, bus.warn}, 0);

        // load 1:02, start, 3 ticks
        do_load(1, 2);
        chk("ld102", mmss(), 102);
        chk("ld102_idle", {bus.running, bus.paused, bus.done}, 0);
        do_start();
        chk("run1", bus.running, 1);
        do_tick(); chk("t1_101", mmss(), 101);
        do_tick(); chk("t2_100", mmss(), 100);
        do_tick(); chk("t3_059", mmss(), 59);
        chk("run_after3", bus.running, 1);

        // load 0:02, run to expiry without auto-reload
        do_load(0, 2);
        do_start();
        do_tick();
        chk("e_001", mmss(), 1);
        chk("e_noexp", bus.expired, 0);
        do_tick();
        chk("e_000", mmss(), 0);
        chk("e_exp", bus.expired, 1);
        chk("e_done", {bus.done, bus.running}, 2'b10);
        cyc();
        chk("e_exp_pulse", bus.expired, 0);
        do_tick();
        chk("e_stay0", mmss(), 0);
        chk("e_stay_done", bus.done, 1);
        // start in DONE reloads the preset
        do_start();
        chk("d_reload", mmss(), 2);
        chk("d_run", bus.running, 1);

        // auto-reload 0:03, 6 ticks
        bus.auto_reload = 1'b1;
        do_load(0, 3);
        do_start();
        do_tick(); chk("a1", mmss(), 2); chk("a1x", bus.expired, 0);
        do_tick(); chk("a2", mmss(), 1); chk("a2x", bus.expired, 0);
        do_tick(); chk("a3", mmss(), 3); chk("a3x", bus.expired, 1);
        chk("a3run", {bus.running, bus.done}, 2'b10);
        do_tick(); chk("a4", mmss(), 2); chk("a4x", bus.expired, 0);
        do_tick(); chk("a5", mmss(), 1);
        do_tick(); chk("a6", mmss(), 3); chk("a6x", bus.expired, 1);
        chk("a6run", bus.running, 1);
        bus.auto_reload = 1'b0;

        // saturation, hold, stop with tick, resume
        do_load(120, 63);
        chk("sat", mmss(), 9959);
        do_start();
        bus.hold = 1'b1;
        for (int i = 0; i < 5; i++) do_tick();
        chk("hold_cnt", mmss(), 9959);
        chk("hold_run", bus.running, 1);
        bus.hold = 1'b0;
        bus.stop = 1'b1; bus.tick = 1'b1;
        cyc();
        bus.stop = 1'b0; bus.tick = 1'b0;
        chk("stop_pause", {bus.running, bus.paused}, 2'b01);
        chk("stop_cnt", mmss(), 9959);
        do_tick();
        chk("pause_tick", mmss(), 9959);
        do_start();
        chk("resume", bus.running, 1);
        do_tick();
        chk("resume_dec", mmss(), 9958);

        // warning window
        do_load(0, 12);
        do_start();
        do_tick();
        chk("w_011", mmss(), 11);
        chk("w_off", bus.warn, 0);
        do_tick();
        chk("w_010", mmss(), 10);
        chk("w_on", bus.warn, 1);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        chk("w_pause", bus.warn, 0);
        bus.tick = 1'b1;
        do_load(0, 5);
        bus.tick = 1'b0;
        chk("lt_cnt", mmss(), 5);
        chk("lt_idle", {bus.running, bus.paused, bus.done}, 0);
        // start with tick from IDLE: enter RUN, no decrement
        bus.tick = 1'b1;
        do_start();
        bus.tick = 1'b0;
        chk("st_tick_run", bus.running, 1);
        chk("st_tick_cnt", mmss(), 5);

        // async reset mid-count
        do_load(5, 0);
        do_start();
        do_tick(); chk("r_459", mmss(), 459);
        do_tick(); chk("r_458", mmss(), 458);
        #2;
        RST = 1'b1;
        #1;
        chk("r_async_cnt", mmss(), 0);
        chk("r_async_flags", {bus.running, bus.expired}, 0);
        cyc();
        RST = 1'b0;
        do_start();
        chk("r_start_ign", {bus.running, bus.done}, 0);
        do_tick();
        chk("r_stay0", mmss(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/countdown_timer_core.md
# countdown_timer_core

Parametrised countdown timer core for the Countdown-Clock design: a minutes/seconds down-counter with arbitrary load values, a start/stop/done state machine, hold freeze, optional auto-reload and a low-time warning flag. It runs in the single system clock domain, advances on a one-cycle `tick` enable from the 1 Hz prescaler, and drives `Qm`/`Qs` into the display decode path in place of fixed-preset timer logic.

## Interface
- `MIN_W`, 7: width of the minutes count.
- `MAX_MIN`, 99: largest loadable minutes value; must be ≤ 2^MIN_W − 1.
- `WARN_SEC`, 10: `warn` asserts when remaining time ≤ this many seconds; range 0–59.
- `CLK` in 1: system clock; all state updates on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle count enable, 1 Hz rate.
- `load` in 1: pulse; captures `load_min`/`load_sec`.
- `load_min` in MIN_W: minutes preset.
- `load_sec` in 6: seconds preset.
- `start` in 1: pulse; begin or resume counting.
- `stop` in 1: pulse; pause counting.
- `hold` in 1: level; freezes the count while high; state unchanged.
- `auto_reload` in 1: level; reload the preset on expiry instead of stopping.
- `Qm` out MIN_W: minutes remaining.
- `Qs` out 6: seconds remaining, 0–59.
- `running` out 1: state is RUN.
- `paused` out 1: state is PAUSE.
- `done` out 1: state is DONE.
- `expired` out 1: one-cycle pulse when the count reaches zero.
- `warn` out 1: RUN and remaining time ≤ WARN_SEC s.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset: IDLE, `Qm`=0, `Qs`=0, reload registers 0, `expired`=0. `running`/`paused`/`done`/`warn` are decoded from registered state and count, so all are 0.
- Load: when `load`=1, `load_sec` is saturated to 59 and `load_min` to MAX_MIN. The saturated values go into `Qm`/`Qs` and the reload registers. State becomes IDLE, from any state.
- `start`:
  - IDLE or PAUSE, count nonzero → RUN.
  - IDLE or PAUSE, count 0:00 → ignored.
  - DONE → `Qm`/`Qs` reloaded from the reload registers; → RUN if the reload value is nonzero, else stays DONE.
- `stop`: RUN → PAUSE. Ignored in other states.
- Decrement: occurs only when state is RUN at the edge, `tick`=1, `hold`=0, and no `load`/`stop` is present.
  - `Qs`>0 → `Qs`−1.
  - `Qs`=0 and `Qm`>0 → `Qs`=59, `Qm`−1.
- Expiry: a decrement from 0:01 sets `expired`=1 for exactly one cycle.
  - `auto_reload`=0: count becomes 0:00 and state → DONE.
  - `auto_reload`=1: count takes the reload value and state stays RUN. The period is exactly the preset number of ticks.
- Priority in the same cycle: `RST` > `load` > `start` > `stop` > decrement.
  - A tick coincident with `load` or `stop` is discarded.
  - `start` in IDLE together with `tick`: → RUN, no decrement that cycle.
- `hold` in PAUSE, IDLE or DONE has no effect. `start`/`stop`/`load` still act while `hold`=1.
- `warn` = RUN && `Qm`=0 && `Qs` ≤ WARN_SEC && `Qs`≠0 is false only at 0:00. It is 0 in PAUSE.

## Timing
- All registers update on the `CLK` rising edge. `RST` clears them immediately, independent of `CLK`. Release of `RST` is synchronous to the design.
- Load latency: 1 cycle; `Qm`/`Qs` are valid the cycle after `load`.
- Count latency: `Qm`/`Qs` change the cycle after a qualifying `tick`.
- `expired` is registered and asserts in the same cycle as the 0:00 (or reload) value.
- `done` asserts in the same cycle as `expired`.
- `RST` mid-count: everything returns to reset values, including the reload registers. `expired` is not generated.
- Arithmetic: `Qs` never exceeds 59; `Qm` never wraps below 0; no decrement occurs at 0:00.

## Test plan
- Reset, then load 1:02, `start`, 3 ticks → `Qm:Qs` = 1:01, 1:00, 0:59; `running`=1.
- Load 0:02, `start`, 2 ticks, `auto_reload`=0 → 0:01, then 0:00 with `expired` high for 1 cycle. `done`=1; further ticks leave 0:00.
- Load 0:03, `auto_reload`=1, 6 ticks → 0:02, 0:01, 0:03 (`expired` pulse), 0:02, 0:01, 0:03 (`expired` pulse); `running` stays 1.
- Load `load_min`=120, `load_sec`=63 → 99:59. `hold`=1 for 5 ticks → unchanged. `stop` with `tick` → PAUSE, still 99:59. `start` → RUN.
- Load 0:12 (WARN_SEC=10), run 2 ticks → `warn` rises at 0:10. `stop` → `warn`=0. Same-cycle `load` 0:05 and `tick` → 0:05, IDLE.
- Load 5:00, `start`, 2 ticks, assert `RST` between `CLK` edges → outputs 0 immediately. After release, `start` is ignored at 0:00.
